// File: rtl/seven_segment_scan.sv
// Multiplexed 7-segment scanner: walks NUM_DIGITS anodes with a blanking tail per slot,
// feeding a one-cycle registered cathode encoder from a once-per-frame input snapshot.
module seven_segment_scan #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_points,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  output logic [3:0]              encoded,
  output logic                    digit_point,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);

  localparam int CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // One bit wider so REFRESH_CYCLES itself (BLANK_CYCLES == 0) stays representable.
  localparam logic [CNT_W:0] DISP_END = (CNT_W + 1)'(REFRESH_CYCLES - BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] ONE_LSB = NUM_DIGITS'(1);

  typedef enum logic {
    PH_DISPLAY = 1'b0,
    PH_BLANK   = 1'b1
  } phase_e;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    load_pending_q;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_points_q, sh_points_d;
  logic [NUM_DIGITS-1:0]   sh_enable_q, sh_enable_d;
  logic [3:0]              encoded_q, encoded_d;
  logic                    digit_point_q, digit_point_d;
  logic                    frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0]   a1_q, a1_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;

  phase_e                  phase_s;
  logic                    slot_end_s;
  logic                    load_s;
  logic                    lit_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic [3:0]              sh_nib_s [NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign sh_nib_s[g] = sh_digits_q[4*g +: 4];
  end

  always_comb begin
    phase_s    = ({1'b0, cnt_q} < DISP_END) ? PH_DISPLAY : PH_BLANK;
    slot_end_s = (cnt_q == CNT_LAST);
    load_s     = load_pending_q || (slot_end_s && (idx_q == IDX_LAST));
    lit_s      = (phase_s == PH_DISPLAY) && sh_enable_q[idx_q];
    onehot_s   = ONE_LSB << idx_q;

    if (slot_end_s) begin
      cnt_d = CNT_W'(0);
      idx_d = (idx_q == IDX_LAST) ? IDX_W'(0) : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end

    if (load_s) begin
      sh_digits_d = digits;
      sh_points_d = digit_points;
      sh_enable_d = digit_enable;
    end else begin
      sh_digits_d = sh_digits_q;
      sh_points_d = sh_points_q;
      sh_enable_d = sh_enable_q;
    end

    encoded_d     = sh_nib_s[idx_q];
    digit_point_d = ~(sh_points_q[idx_q] & lit_s);
    frame_start_d = (cnt_q == CNT_W'(0)) && (idx_q == IDX_W'(0));
    // Anode lags one extra stage to line up with the external cathode register.
    a1_d          = lit_s ? ~onehot_s : ALL_OFF;
    anode_d       = a1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q          <= CNT_W'(0);
      idx_q          <= IDX_W'(0);
      load_pending_q <= 1'b1;
      sh_digits_q    <= {(4*NUM_DIGITS){1'b0}};
      sh_points_q    <= {NUM_DIGITS{1'b0}};
      sh_enable_q    <= {NUM_DIGITS{1'b0}};
      encoded_q      <= 4'h0;
      digit_point_q  <= 1'b1;
      frame_start_q  <= 1'b0;
      a1_q           <= ALL_OFF;
      anode_q        <= ALL_OFF;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      load_pending_q <= 1'b0;
      sh_digits_q    <= sh_digits_d;
      sh_points_q    <= sh_points_d;
      sh_enable_q    <= sh_enable_d;
      encoded_q      <= encoded_d;
      digit_point_q  <= digit_point_d;
      frame_start_q  <= frame_start_d;
      a1_q           <= a1_d;
      anode_q        <= anode_d;
    end
  end

  assign encoded     = encoded_q;
  assign digit_point = digit_point_q;
  assign anode       = anode_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: two instances (blanking 2 and 0) checked cycle by cycle
// against a cycle-count model, plus per-frame aggregate vectors and hand-written corner cases.
module tb_seven_segment_scan;
  localparam int N = 8;
  localparam int R = 8;
  localparam int B = 2;
  localparam int FRAME = N * R;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] digits;
  logic [7:0]  points, enable;
  logic [3:0]  enc2, enc0;
  logic        dp2, dp0, fs2, fs0;
  logic [7:0]  an2, an0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {logic [3:0] enc; logic dp2; logic dp0; logic fs;} st1_t;
  typedef struct {logic [7:0] a2; logic [7:0] a0; logic [3:0] nib;} st2_t;
  typedef struct {logic [31:0] dig; logic [7:0] pt; logic [7:0] en;
                  int lit2; int lit0; int dpl2; int dpl0;} vec_t;

  st1_t        st1_q[$];
  st2_t        st2_q[$];
  int          m_n;
  logic        model_on = 1'b0;
  logic [31:0] sn_dig;
  logic [7:0]  sn_pt, sn_en;
  logic [6:0]  seg_cur, seg_pend;
  vec_t        tbl[5];

  always #5 clk = ~clk;

  seven_segment_scan #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B)) u_dut (
    .clk(clk), .reset(reset), .digits(digits), .digit_points(points), .digit_enable(enable),
    .encoded(enc2), .digit_point(dp2), .anode(an2), .frame_start(fs2));

  seven_segment_scan #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .digits(digits), .digit_points(points), .digit_enable(enable),
    .encoded(enc0), .digit_point(dp0), .anode(an0), .frame_start(fs0));

  // Active-low gfedcba segment code, as the downstream cathode encoder produces it.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  4'hF: seg7 = 7'b0001110;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    st1_q.delete();
    st2_q.delete();
    st2_q.push_back('{a2: 8'hFF, a0: 8'hFF, nib: 4'h0});
    m_n = 0;
    sn_dig = 32'h0;
    sn_pt = 8'h00;
    sn_en = 8'h00;
    seg_pend = 7'h7F;
    model_on = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_enc"}, 32'(enc2), 32'h0);
    check({tag, "_dp"}, 32'(dp2), 32'h1);
    check({tag, "_anode"}, 32'(an2), 32'hFF);
    check({tag, "_fs"}, 32'(fs2), 32'h0);
    check({tag, "_anode_b0"}, 32'(an0), 32'hFF);
    check({tag, "_dp_b0"}, 32'(dp0), 32'h1);
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fs2 && k < 4 * FRAME);
    check("frame_start_wait", 32'(fs2), 32'h1);
  endtask

  // Model: state index m_n counts edges since reset release; shadow reloads at edge 1 and at frame wraps.
  initial begin : model
    int cnt, idx;
    logic [2:0] ix;
    logic disp2;
    st1_t e1;
    st2_t e2;
    forever begin
      @(posedge clk);
      if (model_on && !reset) begin
        cnt = m_n % R;
        idx = (m_n / R) % N;
        ix = 3'(idx);
        disp2 = (cnt < R - B);
        e1.enc = sn_dig[{ix, 2'b00} +: 4];
        e1.dp2 = ~(sn_pt[ix] & sn_en[ix] & disp2);
        e1.dp0 = ~(sn_pt[ix] & sn_en[ix]);
        e1.fs  = (cnt == 0) && (idx == 0);
        e2.a2  = (disp2 && sn_en[ix]) ? ~(8'h01 << ix) : 8'hFF;
        e2.a0  = sn_en[ix] ? ~(8'h01 << ix) : 8'hFF;
        e2.nib = e1.enc;
        st1_q.push_back(e1);
        st2_q.push_back(e2);
        if (m_n == 0 || (cnt == R - 1 && idx == N - 1)) begin
          sn_dig = digits;
          sn_pt  = points;
          sn_en  = enable;
        end
        m_n++;
      end
    end
  end

  // Scoreboard: stage-1 outputs pop this cycle's entry, anodes pop the previous cycle's.
  initial begin : chk
    st1_t e1;
    st2_t e2;
    forever begin
      @(negedge clk);
      if (model_on && !reset) begin
        seg_cur = seg_pend;
        if (st1_q.size() > 0) begin
          e1 = st1_q.pop_front();
          check("encoded", 32'(enc2), 32'(e1.enc));
          check("encoded_b0", 32'(enc0), 32'(e1.enc));
          check("digit_point", 32'(dp2), 32'(e1.dp2));
          check("digit_point_b0", 32'(dp0), 32'(e1.dp0));
          check("frame_start", 32'(fs2), 32'(e1.fs));
          check("frame_start_b0", 32'(fs0), 32'(e1.fs));
        end
        if (st2_q.size() > 1) begin
          e2 = st2_q.pop_front();
          check("anode", 32'(an2), 32'(e2.a2));
          check("anode_b0", 32'(an0), 32'(e2.a0));
          if (e2.a2 != 8'hFF) check("cathode", 32'(seg_cur), 32'(seg7(e2.nib)));
        end
        seg_pend = seg7(enc2);
      end
    end
  end

  initial begin
    int l2, l0, d2, d0;
    tbl[0] = '{32'h76543210, 8'h00, 8'hFF, 48, 64, 0, 0};
    tbl[1] = '{32'hFEDCBA98, 8'h00, 8'hFF, 48, 64, 0, 0};
    tbl[2] = '{32'h76543210, 8'h02, 8'hAA, 24, 32, 6, 8};
    tbl[3] = '{32'h76543210, 8'hFF, 8'h0F, 24, 32, 24, 32};
    tbl[4] = '{32'h76543210, 8'h00, 8'h00, 0, 0, 0, 0};

    digits = 32'h76543210;
    points = 8'h00;
    enable = 8'hFF;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      digits = tbl[i].dig;
      points = tbl[i].pt;
      enable = tbl[i].en;
      wait_fs();
      wait_fs();
      l2 = 0; l0 = 0; d2 = 0; d0 = 0;
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        if (an2 != 8'hFF) l2++;
        if (an0 != 8'hFF) l0++;
        if (!dp2) d2++;
        if (!dp0) d0++;
      end
      check($sformatf("vec%0d_lit", i), 32'(l2), 32'(tbl[i].lit2));
      check($sformatf("vec%0d_lit_b0", i), 32'(l0), 32'(tbl[i].lit0));
      check($sformatf("vec%0d_dp", i), 32'(d2), 32'(tbl[i].dpl2));
      check($sformatf("vec%0d_dp_b0", i), 32'(d0), 32'(tbl[i].dpl0));
    end

    // Snapshot atomicity: change digits during digit 3's slot.
    @(negedge clk);
    digits = 32'h76543210;
    points = 8'h00;
    enable = 8'hFF;
    wait_fs();
    wait_fs();
    repeat (26) @(negedge clk);
    check("t2_mid_enc", 32'(enc2), 32'h3);
    digits = 32'hFEDCBA98;
    wait_fs();
    check("t2_new_at_fs", 32'(enc2), 32'h8);
    @(negedge clk);
    check("t2_anode0", 32'(an2), 32'hFE);

    // Mid-frame reset at idx=5, cnt=3.
    wait_fs();
    repeat (42) @(negedge clk);
    check("t5_pre_anode", 32'(an2), 32'hDF);
    check("t5_pre_enc", 32'(enc2), 32'hD);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("held");
    reset = 1'b0;
    @(negedge clk);
    check("t5_first_fs", 32'(fs2), 32'h1);
    check("t5_first_anode", 32'(an2), 32'hFF);
    repeat (2 * FRAME + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
